// File: rtl/duckhunt_pkg.sv
// Shared types and constants for the Duck Hunt mouse front end:
// packet FSM states, screen geometry and PS/2 status-byte field positions.
package duckhunt_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int LEFT_BIT   = 0;
    localparam int RIGHT_BIT  = 1;
    localparam int MIDDLE_BIT = 2;
    localparam int SYNC_BIT   = 3;
    localparam int X_SIGN_BIT = 4;
    localparam int Y_SIGN_BIT = 5;
    localparam int X_OVF_BIT  = 6;
    localparam int Y_OVF_BIT  = 7;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } mouse_state_t;

    // Status byte with the always-one sync bit dropped.
    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic middle;
        logic right;
        logic left;
    } status_t;

    function automatic status_t decode_status(input logic [7:0] b);
        status_t s;
        s.y_ovf  = b[Y_OVF_BIT];
        s.x_ovf  = b[X_OVF_BIT];
        s.y_sign = b[Y_SIGN_BIT];
        s.x_sign = b[X_SIGN_BIT];
        s.middle = b[MIDDLE_BIT];
        s.right  = b[RIGHT_BIT];
        s.left   = b[LEFT_BIT];
        return s;
    endfunction

endpackage

// File: rtl/axis_accum.sv
// One cursor axis: position +/- signed 9-bit delta, clamped to [0, MAX].
// Purely combinational; the caller registers the result.
module axis_accum #(
    parameter int MAX = 639
) (
    input  logic [9:0]        pos_i,
    input  logic signed [8:0] delta_i,
    input  logic              sub_i,
    output logic [9:0]        pos_o
);

    localparam logic [9:0] MAX_P = 10'(MAX);

    logic signed [11:0] pos_ext;
    logic signed [11:0] delta_ext;
    logic signed [11:0] sum;

    // 12 bits covers -256..(1023+256), so the clamp tests cannot wrap.
    always_comb begin
        pos_ext   = signed'({2'b00, pos_i});
        delta_ext = signed'({{3{delta_i[8]}}, delta_i});
        sum       = sub_i ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
        if (sum[11]) begin
            pos_o = 10'd0;
        end else if (sum > signed'({2'b00, MAX_P})) begin
            pos_o = MAX_P;
        end else begin
            pos_o = sum[9:0];
        end
    end

endmodule

// File: rtl/mouse_tracker.sv
// Assembles 3-byte PS/2 mouse packets and applies them to a clamped absolute
// cursor, button state and left-click counter.
module mouse_tracker
    import duckhunt_pkg::*;
#(
    parameter int X_MAX          = SCREEN_W - 1,
    parameter int Y_MAX          = SCREEN_H - 1,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic [9:0] mouseX,
    output logic [9:0] mouseY,
    output logic [7:0] mouseButton,
    output logic [7:0] click_count,
    output logic       packet_valid
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mouse_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    status_t          status_q, status_d;
    logic [7:0]       dx_lo_q, dx_lo_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [7:0]       btn_q, btn_d;
    logic [7:0]       clicks_q, clicks_d;
    logic             pv_q, pv_d;

    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic [9:0]        x_next;
    logic [9:0]        y_next;

    // Overflowed axes contribute no movement; byte 2 feeds dy straight from the bus.
    assign dx = status_q.x_ovf ? 9'sd0 : signed'({status_q.x_sign, dx_lo_q});
    assign dy = status_q.y_ovf ? 9'sd0 : signed'({status_q.y_sign, byte_data});

    axis_accum #(.MAX(X_MAX)) u_x_accum (
        .pos_i   (x_q),
        .delta_i (dx),
        .sub_i   (1'b0),
        .pos_o   (x_next)
    );

    // PS/2 Y is positive-up while screen Y grows downward, hence subtract.
    axis_accum #(.MAX(Y_MAX)) u_y_accum (
        .pos_i   (y_q),
        .delta_i (dy),
        .sub_i   (1'b1),
        .pos_o   (y_next)
    );

    // NOTE: every _d gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        dx_lo_d  = dx_lo_q;
        x_d      = x_q;
        y_d      = y_q;
        btn_d    = btn_q;
        clicks_d = clicks_q;
        pv_d     = 1'b0;

        unique case (state_q)
            WAIT_B0: begin
                cnt_d = '0;
                if (byte_valid && byte_data[SYNC_BIT]) begin
                    status_d = decode_status(byte_data);
                    state_d  = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (byte_valid) begin
                    dx_lo_d = byte_data;
                    cnt_d   = '0;
                    state_d = WAIT_B2;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_B0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_B2: begin
                if (byte_valid) begin
                    x_d   = x_next;
                    y_d   = y_next;
                    btn_d = {5'b0, status_q.middle, status_q.right, status_q.left};
                    if (!btn_q[LEFT_BIT] && status_q.left) begin
                        clicks_d = clicks_q + 8'd1;
                    end
                    pv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_B0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_B0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = WAIT_B0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments; reset here is synchronous, so it is just the first branch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= WAIT_B0;
            cnt_q    <= '0;
            status_q <= '0;
            dx_lo_q  <= '0;
            x_q      <= 10'(X_INIT);
            y_q      <= 10'(Y_INIT);
            btn_q    <= '0;
            clicks_q <= '0;
            pv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            dx_lo_q  <= dx_lo_d;
            x_q      <= x_d;
            y_q      <= y_d;
            btn_q    <= btn_d;
            clicks_q <= clicks_d;
            pv_q     <= pv_d;
        end
    end

    assign mouseX       = x_q;
    assign mouseY       = y_q;
    assign mouseButton  = btn_q;
    assign click_count  = clicks_q;
    assign packet_valid = pv_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// Directed-vector bench for mouse_tracker: expected packet results are queued
// as stimulus is sent and a negedge monitor compares them on each packet_valid.
module tb_mouse_tracker;

    localparam int T = 100;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic [9:0] mouseX;
    logic [9:0] mouseY;
    logic [7:0] mouseButton;
    logic [7:0] click_count;
    logic       packet_valid;

    mouse_tracker #(.TIMEOUT_CYCLES(T)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .mouseX       (mouseX),
        .mouseY       (mouseY),
        .mouseButton  (mouseButton),
        .click_count  (click_count),
        .packet_valid (packet_valid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] b;
        logic [7:0] c;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   pulses = 0;
    int   expected_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called just after a rising edge; the byte is sampled on the next edge.
    task automatic send_byte(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        @(posedge Clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [9:0] ex, input logic [9:0] ey,
                            input logic [7:0] eb, input logic [7:0] ec);
        exp_t e;
        send_byte(b0);
        send_byte(b1);
        e.x = ex; e.y = ey; e.b = eb; e.c = ec;
        sb_q.push_back(e);
        expected_pulses++;
        send_byte(b2);
    endtask

    // Monitor: pops one expectation per packet_valid pulse.
    initial begin
        logic pv_prev;
        exp_t e;
        pv_prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                pv_prev = 1'b0;
            end else begin
                if (packet_valid) begin
                    pulses++;
                    check($sformatf("pv_single_cycle pkt%0d", pulses), {31'b0, pv_prev}, 32'd0);
                    if (sb_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected_packet: got packet_valid=1, expected no packet (X=%0d Y=%0d)",
                                 mouseX, mouseY);
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("mouseX pkt%0d", pulses), 32'(mouseX), 32'(e.x));
                        check($sformatf("mouseY pkt%0d", pulses), 32'(mouseY), 32'(e.y));
                        check($sformatf("mouseButton pkt%0d", pulses), 32'(mouseButton), 32'(e.b));
                        check($sformatf("click_count pkt%0d", pulses), 32'(click_count), 32'(e.c));
                    end
                end
                pv_prev = packet_valid;
            end
        end
    end

    initial begin
        exp_t e;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("reset mouseX", 32'(mouseX), 32'd320);
        check("reset mouseY", 32'(mouseY), 32'd240);
        check("reset mouseButton", 32'(mouseButton), 32'd0);
        check("reset click_count", 32'(click_count), 32'd0);
        check("reset packet_valid", 32'(packet_valid), 32'd0);
        Reset = 1'b0;
        idle(2);
        check("idle packet_valid", 32'(packet_valid), 32'd0);

        // Basic move, with outputs held mid-packet.
        send_byte(8'h08);
        send_byte(8'h0A);
        check("mid-packet mouseX", 32'(mouseX), 32'd320);
        e.x = 10'd330; e.y = 10'd235; e.b = 8'd0; e.c = 8'd0;
        sb_q.push_back(e);
        expected_pulses++;
        send_byte(8'h05);

        // X to the right edge and clamp.
        send_pkt(8'h08, 8'hFF, 8'h00, 10'd585, 10'd235, 8'd0, 8'd0);
        send_pkt(8'h08, 8'h2D, 8'h00, 10'd630, 10'd235, 8'd0, 8'd0);
        send_pkt(8'h08, 8'h14, 8'h00, 10'd639, 10'd235, 8'd0, 8'd0);
        // Y to the bottom (negative dy moves down) and clamp.
        send_pkt(8'h28, 8'h00, 8'h15, 10'd639, 10'd470, 8'd0, 8'd0);
        send_pkt(8'h28, 8'h00, 8'hEC, 10'd639, 10'd479, 8'd0, 8'd0);
        // Y to the top and clamp at 0.
        send_pkt(8'h08, 8'h00, 8'hFF, 10'd639, 10'd224, 8'd0, 8'd0);
        send_pkt(8'h08, 8'h00, 8'hDB, 10'd639, 10'd5,   8'd0, 8'd0);
        send_pkt(8'h08, 8'h00, 8'h0A, 10'd639, 10'd0,   8'd0, 8'd0);
        // X with the most negative delta, clamping at 0.
        send_pkt(8'h18, 8'h00, 8'h00, 10'd383, 10'd0, 8'd0, 8'd0);
        send_pkt(8'h18, 8'h00, 8'h00, 10'd127, 10'd0, 8'd0, 8'd0);
        send_pkt(8'h18, 8'h00, 8'h00, 10'd0,   10'd0, 8'd0, 8'd0);
        // Left-button edges and other buttons.
        send_pkt(8'h09, 8'h00, 8'h00, 10'd0, 10'd0, 8'd1, 8'd1);
        send_pkt(8'h09, 8'h00, 8'h00, 10'd0, 10'd0, 8'd1, 8'd1);
        send_pkt(8'h08, 8'h00, 8'h00, 10'd0, 10'd0, 8'd0, 8'd1);
        send_pkt(8'h09, 8'h00, 8'h00, 10'd0, 10'd0, 8'd1, 8'd2);
        send_pkt(8'h0E, 8'h00, 8'h00, 10'd0, 10'd0, 8'd6, 8'd2);
        // Sync: a byte without bit 3 is dropped in WAIT_B0.
        send_byte(8'h00);
        send_pkt(8'h08, 8'h05, 8'h00, 10'd5, 10'd0, 8'd0, 8'd2);
        // Overflow forces the axis delta to zero; buttons still update.
        send_pkt(8'h48, 8'h7F, 8'h00, 10'd5, 10'd0,   8'd0, 8'd2);
        send_pkt(8'h28, 8'h00, 8'h9C, 10'd5, 10'd100, 8'd0, 8'd2);
        send_pkt(8'h88, 8'h00, 8'h32, 10'd5, 10'd100, 8'd0, 8'd2);
        send_pkt(8'h89, 8'h00, 8'h32, 10'd5, 10'd100, 8'd1, 8'd3);

        // Timeout in WAIT_B2 discards the partial packet.
        send_byte(8'h08);
        send_byte(8'h05);
        idle(T);
        send_pkt(8'h08, 8'h03, 8'h00, 10'd8, 10'd100, 8'd0, 8'd3);
        // Timeout in WAIT_B1.
        send_byte(8'h08);
        idle(T);
        send_pkt(8'h08, 8'h02, 8'h00, 10'd10, 10'd100, 8'd0, 8'd3);
        // Byte arriving on the expiry cycle is accepted.
        send_byte(8'h08);
        send_byte(8'h04);
        idle(T - 1);
        e.x = 10'd14; e.y = 10'd100; e.b = 8'd0; e.c = 8'd3;
        sb_q.push_back(e);
        expected_pulses++;
        send_byte(8'h00);
        idle(3);

        // Reset between byte 1 and byte 2.
        send_byte(8'h08);
        send_byte(8'h07);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("post-reset mouseX", 32'(mouseX), 32'd320);
        check("post-reset mouseY", 32'(mouseY), 32'd240);
        check("post-reset mouseButton", 32'(mouseButton), 32'd0);
        check("post-reset click_count", 32'(click_count), 32'd0);
        send_byte(8'h00);
        send_pkt(8'h08, 8'h01, 8'h01, 10'd321, 10'd239, 8'd0, 8'd0);

        idle(5);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        check("packet count", 32'(pulses), 32'(expected_pulses));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
